// File: rtl/mult_shift_add.sv
// rtl/mult_shift_add.sv - signed 8x8 -> 16 shift-and-add multiplier, two-stage pipeline
//
// Forms operand magnitudes, sums two groups of four shifted partial
// products in stage 1, then adds the groups and restores the sign in stage 2.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset, clears all pipeline state
//   i_valid    operand strobe; i_a/i_b sampled when high
//   i_a        signed multiplicand (8 bits)
//   i_b        signed multiplier (8 bits)
//   o_product  signed registered product (16 bits), held until next result
//   o_done     one-cycle pulse marking a new o_product
module mult_shift_add (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_product,
  output logic        o_done
);

  logic [7:0]  w_mag_a;
  logic [7:0]  w_mag_b;
  logic [15:0] w_pp [8];
  logic [15:0] w_s_lo;
  logic [15:0] w_s_hi;
  logic [15:0] w_mag;

  logic [15:0] r_s_lo;
  logic [15:0] r_s_hi;
  logic        r_sign;
  logic        r_v1;

  // Unsigned magnitudes; -128 negates to 8'h80, which reads as 128 unsigned.
  assign w_mag_a = i_a[7] ? (~i_a + 8'd1) : i_a;
  assign w_mag_b = i_b[7] ? (~i_b + 8'd1) : i_b;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_pp[i] = w_mag_b[i] ? ({8'd0, w_mag_a} << i) : 16'd0;
    end
  end

  assign w_s_lo = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];
  assign w_s_hi = w_pp[4] + w_pp[5] + w_pp[6] + w_pp[7];

  // Stage 1: partial sums, sign and valid flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s_lo <= 16'd0;
      r_s_hi <= 16'd0;
      r_sign <= 1'b0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_s_lo <= w_s_lo;
        r_s_hi <= w_s_hi;
        r_sign <= i_a[7] ^ i_b[7];
      end
    end
  end

  // Max magnitude is 128*128 = 16384, so 16-bit add cannot overflow.
  assign w_mag = r_s_lo + r_s_hi;

  // Stage 2: final magnitude and sign. Negating a zero magnitude yields +0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_product <= 16'd0;
      o_done    <= 1'b0;
    end else begin
      o_done <= r_v1;
      if (r_v1) begin
        o_product <= r_sign ? (~w_mag + 16'd1) : w_mag;
      end
    end
  end

endmodule

// File: tb/tb_mult_shift_add.sv
// tb/tb_mult_shift_add.sv - self-checking bench for mult_shift_add
module tb_mult_shift_add;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        done;

  int tests_run;
  int tests_failed;

  mult_shift_add dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .i_a       (a),
    .i_b       (b),
    .o_product (product),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; a = 8'd9; b = 8'd9;
    repeat (2) @(negedge clk);
    tests_run++;
    if (product !== 16'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: product=%h done=%b required product=0000 done=0", product, done);
    end
    valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (product !== 16'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: product=%h done=%b required product=0000 done=0", product, done);
    end
  endtask

  // One isolated op: done on the second edge, then product held with done low.
  task automatic single_op(input string name, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] e;
    e = ref_mul(x, y);
    valid = 1'b1; a = x; b = y;
    @(negedge clk);
    valid = 1'b0; a = $urandom; b = $urandom;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_early_done: done=%b required 0", name, done);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || product !== e) begin
      tests_failed++;
      $display("FAIL %s: product=%h done=%b required product=%h done=1", name, product, done, e);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || product !== e) begin
      tests_failed++;
      $display("FAIL %s_hold: product=%h done=%b required product=%h done=0", name, product, done, e);
    end
  endtask

  task automatic test_directed();
    single_op("basic",     8'd10,   8'd20);
    single_op("max_pos",   8'd127,  8'd127);
    single_op("mixed",     8'hFB,   8'd4);
    single_op("neg128sq",  8'h80,   8'h80);
    single_op("neg128x127", 8'h80,  8'd127);
    single_op("zero",      8'd0,    8'hF9);
    single_op("neg1sq",    8'hFF,   8'hFF);
    single_op("pos_x_neg128", 8'd1, 8'h80);
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 20; i++) begin
      single_op("rand_single", 8'($urandom), 8'($urandom));
    end
  endtask

  // Streaming model: done at cycle c reflects the valid driven at cycle c-2;
  // product holds the most recent completed result.
  task automatic run_stream(input string name, input int n, input int valid_pct,
                            input logic [7:0] fa [$], input logic [7:0] fb [$]);
    logic        v_h [$];
    logic [15:0] e_h [$];
    logic [15:0] last;
    logic        vv;
    logic [7:0]  x, y;
    last = product;
    for (int c = 0; c < n + 2; c++) begin
      if (c >= 2) begin
        if (v_h[c-2]) last = e_h[c-2];
        tests_run++;
        if (done !== v_h[c-2] || product !== last) begin
          tests_failed++;
          $display("FAIL %s cycle %0d: product=%h done=%b required product=%h done=%b",
                   name, c, product, done, last, v_h[c-2]);
        end
      end
      if (c < n) begin
        if (c < fa.size()) begin
          vv = 1'b1; x = fa[c]; y = fb[c];
        end else begin
          vv = ($urandom_range(99) < valid_pct);
          x = 8'($urandom); y = 8'($urandom);
        end
      end else begin
        vv = 1'b0; x = 8'($urandom); y = 8'($urandom);
      end
      v_h.push_back(vv);
      e_h.push_back(ref_mul(x, y));
      valid = vv; a = x; b = y;
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] fa [$];
    logic [7:0] fb [$];
    fa = '{8'd3, 8'hFA, 8'd100};
    fb = '{8'd4, 8'd7,  8'hFE};
    run_stream("b2b", 3, 0, fa, fb);
    tests_run++;
    if (done !== 1'b0 || product !== 16'hFF38) begin
      tests_failed++;
      $display("FAIL b2b_tail: product=%h done=%b required product=ff38 done=0", product, done);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] fa [$];
    logic [7:0] fb [$];
    run_stream("rand_stream", 200, 70, fa, fb);
  endtask

  task automatic test_reset_midflight();
    single_op("pre_rst", 8'd50, 8'd50);
    valid = 1'b1; a = 8'd11; b = 8'd13;
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++;
    if (product !== 16'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: product=%h done=%b required product=0000 done=0", product, done);
    end
    valid = 1'b1; a = 8'd7; b = 8'd7;
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (product !== 16'd0 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_flush cycle %0d: product=%h done=%b required product=0000 done=0", i, product, done);
      end
    end
    single_op("post_rst", 8'hF6, 8'd9);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; valid = 1'b0; a = 8'd0; b = 8'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random_single();
    test_back_to_back();
    test_random_stream();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
